exe_mem_stage_reg: RTL and testbench

//  EXE->MEM pipeline register with the processor status register (CPSR flags).
//  - Captures the ALU result, store data, destination and control bits each cycle.
//  - Holds the captured instruction while the memory stage stalls.
//  - Kills a flushed instruction.
//  - Commits ALU flags {Z,C,N,V} when the instruction's S bit is set; the committed C flag feeds the ALU carry-in.

---
 rtl/exe_mem_stage_reg.sv | 74 +++++++
 tb/tb_exe_mem_stage_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register with stall hold, flush-to-bubble and CPSR flag commit.
// A flush that arrives during a stall is parked in HOLD_FLUSH and retired as one bubble.
module exe_mem_stage_reg #(
  parameter int REG_LEN    = 32,
  parameter int DEST_LEN   = 4,
  parameter int STATUS_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  s_bit_in,
  input  logic [REG_LEN-1:0]    alu_res_in,
  input  logic [REG_LEN-1:0]    st_val_in,
  input  logic [DEST_LEN-1:0]   dest_in,
  input  logic [STATUS_LEN-1:0] status_in,
  output logic                  valid,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [REG_LEN-1:0]    alu_res,
  output logic [REG_LEN-1:0]    st_val,
  output logic [DEST_LEN-1:0]   dest,
  output logic [STATUS_LEN-1:0] status_reg,
  output logic                  carry_flag
);

  typedef enum logic {RUN, HOLD_FLUSH} state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      valid      <= 1'b0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      alu_res    <= '0;
      st_val     <= '0;
      dest       <= '0;
      status_reg <= '0;
    end else if (freeze) begin
      // Everything holds; a flush seen now is only remembered.
      if (flush) state <= HOLD_FLUSH;
    end else if (flush || state == HOLD_FLUSH) begin
      state    <= RUN;
      valid    <= 1'b0;
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      st_val   <= '0;
      dest     <= '0;
    end else begin
      valid    <= valid_in;
      wb_en    <= wb_en_in & valid_in;
      mem_r_en <= mem_r_en_in & valid_in;
      mem_w_en <= mem_w_en_in & valid_in;
      alu_res  <= alu_res_in;
      st_val   <= st_val_in;
      dest     <= dest_in;
      if (valid_in && s_bit_in) status_reg <= status_in;
    end
  end

  // Flag order is {Z,C,N,V}, so C sits at bit 2.
  assign carry_flag = status_reg[2];

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Scoreboard bench for exe_mem_stage_reg: expected stage contents are queued per edge
// and compared one cycle later, plus directed checks on the documented scenarios.
module tb_exe_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit_in;
  logic [31:0] alu_res_in, st_val_in;
  logic [3:0]  dest_in, status_in;
  logic        valid, wb_en, mem_r_en, mem_w_en, carry_flag;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest, status_reg;

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic [3:0]  status;
  } exp_t;

  exp_t m;            // reference model of the stage contents
  logic m_pend;       // model: flush parked during a stall
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exe_mem_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .s_bit_in(s_bit_in), .alu_res_in(alu_res_in),
    .st_val_in(st_val_in), .dest_in(dest_in), .status_in(status_in),
    .valid(valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_val(st_val), .dest(dest), .status_reg(status_reg),
    .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check_eq({tag, ".valid"},    {63'd0, valid},    {63'd0, e.valid});
    check_eq({tag, ".wb_en"},    {63'd0, wb_en},    {63'd0, e.wb_en});
    check_eq({tag, ".mem_r_en"}, {63'd0, mem_r_en}, {63'd0, e.mem_r_en});
    check_eq({tag, ".mem_w_en"}, {63'd0, mem_w_en}, {63'd0, e.mem_w_en});
    check_eq({tag, ".alu_res"},  {32'd0, alu_res},  {32'd0, e.alu_res});
    check_eq({tag, ".st_val"},   {32'd0, st_val},   {32'd0, e.st_val});
    check_eq({tag, ".dest"},     {60'd0, dest},     {60'd0, e.dest});
    check_eq({tag, ".status"},   {60'd0, status_reg}, {60'd0, e.status});
    check_eq({tag, ".carry"},    {63'd0, carry_flag}, {63'd0, e.status[2]});
  endtask

  task automatic set_in(input logic fr, input logic fl, input logic v, input logic wb,
                        input logic mr, input logic mw, input logic s, input logic [31:0] a,
                        input logic [31:0] sv, input logic [3:0] d, input logic [3:0] st);
    freeze = fr; flush = fl; valid_in = v; wb_en_in = wb; mem_r_en_in = mr;
    mem_w_en_in = mw; s_bit_in = s; alu_res_in = a; st_val_in = sv; dest_in = d;
    status_in = st;
  endtask

  // Advance the model by one edge, queue its result, then compare after the edge.
  task automatic cycle(input string tag);
    exp_t e;
    if (freeze) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend) begin
      m_pend = 1'b0;
      m.valid = 0; m.wb_en = 0; m.mem_r_en = 0; m.mem_w_en = 0;
      m.alu_res = 0; m.st_val = 0; m.dest = 0;
    end else begin
      m.valid    = valid_in;
      m.wb_en    = wb_en_in & valid_in;
      m.mem_r_en = mem_r_en_in & valid_in;
      m.mem_w_en = mem_w_en_in & valid_in;
      m.alu_res  = alu_res_in;
      m.st_val   = st_val_in;
      m.dest     = dest_in;
      if (valid_in && s_bit_in) m.status = status_in;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_all(tag, e);
  endtask

  // Async reset between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    exp_t z;
    z = '0;
    #2 rst_n = 1'b0;
    #1;
    compare_all(tag, z);
    m = '0; m_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m = '0; m_pend = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    async_reset("reset");

    // Pass-through with flag commit
    set_in(0, 0, 1, 1, 0, 0, 1, 32'h0000_0010, 32'hdead_beef, 4'd3, 4'b0100);
    cycle("pass");
    check_eq("pass.alu_const", {32'd0, alu_res}, 64'h10);
    check_eq("pass.carry_const", {63'd0, carry_flag}, 64'd1);

    // S bit clear: flags must not change
    set_in(0, 0, 1, 1, 1, 0, 0, 32'h0000_0020, 32'h1234_5678, 4'd5, 4'b1001);
    cycle("sclr");
    check_eq("sclr.status_const", {60'd0, status_reg}, 64'b0100);

    // Three-cycle stall with changing inputs
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0, 0, 1, 1, 32'hf000_0000 + i, 32'h0a0a_0a0a, 4'(i + 8), 4'b1111);
      cycle("stall");
      check_eq("stall.alu_const", {32'd0, alu_res}, 64'h20);
    end

    // Deferred flush: pulse during freeze, release two cycles later
    set_in(1, 1, 1, 1, 0, 0, 1, 32'h0000_0044, 32'h0, 4'd1, 4'b0010);
    cycle("dflush_a");
    set_in(1, 0, 1, 1, 0, 0, 1, 32'h0000_0045, 32'h0, 4'd1, 4'b0010);
    cycle("dflush_b");
    set_in(0, 0, 1, 1, 0, 1, 1, 32'h0000_0055, 32'h0, 4'd2, 4'b1000);
    cycle("dflush_bubble");
    check_eq("dflush.valid_const", {63'd0, valid}, 64'd0);
    check_eq("dflush.status_const", {60'd0, status_reg}, 64'b0100);
    set_in(0, 0, 1, 1, 0, 1, 1, 32'h0000_0066, 32'h7777_7777, 4'd6, 4'b1000);
    cycle("dflush_next");
    check_eq("dflush_next.alu_const", {32'd0, alu_res}, 64'h66);

    // Flush with S bit set: no flag commit
    set_in(0, 1, 1, 1, 0, 0, 1, 32'h0000_0099, 32'h1, 4'd7, 4'b1111);
    cycle("flush_s");
    check_eq("flush_s.status_const", {60'd0, status_reg}, 64'b1000);

    // Invalid instruction forces control bits off
    set_in(0, 0, 0, 1, 1, 1, 1, 32'hffff_ffff, 32'hffff_ffff, 4'hf, 4'b0111);
    cycle("inval");

    // Several flushes within one freeze -> exactly one bubble
    set_in(1, 1, 1, 1, 0, 0, 0, 32'h1, 32'h1, 4'd1, 4'b0);
    cycle("mflush_a");
    set_in(1, 1, 1, 1, 0, 0, 0, 32'h2, 32'h2, 4'd2, 4'b0);
    cycle("mflush_b");
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h3, 32'h3, 4'd3, 4'b0);
    cycle("mflush_bubble");
    set_in(0, 0, 1, 1, 0, 0, 0, 32'h4, 32'h4, 4'd4, 4'b0);
    cycle("mflush_cap");

    // Reset while a flush is parked must drop it
    set_in(1, 1, 1, 1, 0, 0, 1, 32'h5, 32'h5, 4'd5, 4'b0110);
    cycle("rst_hold_a");
    set_in(1, 0, 1, 1, 0, 0, 1, 32'h5, 32'h5, 4'd5, 4'b0110);
    async_reset("rst_hold");
    set_in(0, 0, 1, 1, 0, 0, 1, 32'h0000_0abc, 32'h5, 4'd9, 4'b0110);
    cycle("rst_hold_cap");
    check_eq("rst_hold.valid_const", {63'd0, valid}, 64'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
             4'($urandom), 4'($urandom));
      cycle("rand");
      if (i == 150) async_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
